// File: rtl/regfile_writer_pkg.sv
// Shared definitions for the register-file writeback arbiter: default sizing,
// the writeback-entry record, the issue-source encoding and a destination mask helper.
package regfile_writer_pkg;

    localparam int XLEN_DEF         = 32;
    localparam int DEPTH_DEF        = 4;
    localparam int STARVE_LIMIT_DEF = 7;
    localparam int NREG             = 32;

    typedef struct packed {
        logic [4:0]          rd;
        logic [XLEN_DEF-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } issue_src_e;

    // x0 is hardwired to zero, so it never shows up as a pending destination.
    function automatic logic [NREG-1:0] rd_mask(input logic [4:0] rd);
        logic [NREG-1:0] m;
        m = {NREG{1'b0}};
        if (rd != 5'd0) begin
            m[rd] = 1'b1;
        end else begin
            m = {NREG{1'b0}};
        end
        return m;
    endfunction

endpackage

// File: rtl/regfile_writer_wb_fifo.sv
// Late-writeback FIFO: circular storage, wrapping pointers, occupancy count and
// a mask of destination registers held by valid entries.
module wb_fifo
    import regfile_writer_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [4:0]               push_rd_i,
    input  logic [XLEN-1:0]          push_data_i,
    input  logic                     pop_i,
    output logic [4:0]               head_rd_o,
    output logic [XLEN-1:0]          head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [NREG-1:0]          pend_mask_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [4:0]       rd_q   [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s, pop_ok_s;
    logic [NREG-1:0]  pend_s;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == CNT_W'(0));
    assign push_ok_s   = push_i && !full_o;
    assign pop_ok_s    = pop_i && !empty_o;
    assign head_rd_o   = rd_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;
    assign pend_mask_o = pend_s;

    // Next-state pointers and count; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents outside the valid window are never observed.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            rd_q[wr_ptr_q]   <= push_rd_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pending mask: OR of destinations over slots within count of the read pointer.
    always_comb begin
        logic [PTR_W-1:0] offs;
        pend_s = {NREG{1'b0}};
        offs   = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, offs} < count_q) begin
                pend_s = pend_s | rd_mask(rd_q[i]);
            end else begin
                pend_s = pend_s;
            end
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// Register-file write-port arbiter: pipeline writebacks win, late writebacks queue
// in wb_fifo and are forced through after STARVE_LIMIT blocked cycles.
module regfile_writer
    import regfile_writer_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wb_valid_i,
    input  logic [4:0]             wb_rd_i,
    input  logic [XLEN-1:0]        wb_data_i,
    output logic                   wb_ready_o,
    input  logic                   lsu_valid_i,
    input  logic [4:0]             lsu_rd_i,
    input  logic [XLEN-1:0]        lsu_data_i,
    output logic                   lsu_ready_o,
    output logic                   we3_o,
    output logic [4:0]             a3_o,
    output logic [XLEN-1:0]        wd3_o,
    output logic [NREG-1:0]        pend_mask_o,
    output logic [$clog2(DEPTH):0] fifo_count_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0]   starve_q, starve_d;
    logic            we3_q, we3_d;
    logic [4:0]      a3_q, a3_d;
    logic [XLEN-1:0] wd3_q, wd3_d;

    issue_src_e      src_s;
    logic            wb_acc_s, push_s, pop_s;
    logic            full_s, empty_s;
    logic [4:0]      head_rd_s, sel_rd_s;
    logic [XLEN-1:0] head_data_s, sel_data_s;

    assign wb_ready_o  = (starve_q != SW'(STARVE_LIMIT));
    assign lsu_ready_o = !full_s;
    assign wb_acc_s    = wb_valid_i && wb_ready_o;
    assign push_s      = lsu_valid_i && lsu_ready_o;
    assign we3_o       = we3_q;
    assign a3_o        = a3_q;
    assign wd3_o       = wd3_q;

    wb_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push_s),
        .push_rd_i   (lsu_rd_i),
        .push_data_i (lsu_data_i),
        .pop_i       (pop_s),
        .head_rd_o   (head_rd_s),
        .head_data_o (head_data_s),
        .count_o     (fifo_count_o),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .pend_mask_o (pend_mask_o)
    );

    // Issue arbitration and starvation accounting.
    always_comb begin
        src_s      = SRC_NONE;
        pop_s      = 1'b0;
        sel_rd_s   = 5'd0;
        sel_data_s = {XLEN{1'b0}};
        we3_d      = 1'b0;
        a3_d       = a3_q;
        wd3_d      = wd3_q;
        starve_d   = starve_q;

        if (wb_acc_s) begin
            src_s = SRC_PIPE;
        end else if (!empty_s) begin
            src_s = SRC_FIFO;
        end else begin
            src_s = SRC_NONE;
        end
        pop_s = (src_s == SRC_FIFO);

        case (src_s)
            SRC_PIPE: begin
                sel_rd_s   = wb_rd_i;
                sel_data_s = wb_data_i;
            end
            SRC_FIFO: begin
                sel_rd_s   = head_rd_s;
                sel_data_s = head_data_s;
            end
            default: begin
                sel_rd_s   = 5'd0;
                sel_data_s = {XLEN{1'b0}};
            end
        endcase

        // x0 writes are consumed silently; address/data hold their last values.
        we3_d = (src_s != SRC_NONE) && (sel_rd_s != 5'd0);
        if (we3_d) begin
            a3_d  = sel_rd_s;
            wd3_d = sel_data_s;
        end else begin
            a3_d  = a3_q;
            wd3_d = wd3_q;
        end

        if (empty_s || pop_s) begin
            starve_d = {SW{1'b0}};
        end else if (wb_acc_s) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Registered write port and starvation counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we3_q    <= 1'b0;
            a3_q     <= 5'd0;
            wd3_q    <= {XLEN{1'b0}};
            starve_q <= {SW{1'b0}};
        end else begin
            we3_q    <= we3_d;
            a3_q     <= a3_d;
            wd3_q    <= wd3_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_regfile_writer.sv
// Self-checking bench for regfile_writer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_regfile_writer;
    import regfile_writer_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int LIMIT = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        wb_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_rd = 5'd0;
    logic [31:0] lsu_data = 32'd0;
    logic        lsu_ready;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;

    regfile_writer #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data), .wb_ready_o(wb_ready),
        .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
        .we3_o(we3), .a3_o(a3), .wd3_o(wd3), .pend_mask_o(pend_mask), .fifo_count_o(fifo_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: queue of late entries, expected write port, blocked-cycle count.
    wb_entry_t   mq[$];
    logic        exp_we = 1'b0;
    logic [4:0]  exp_a3 = 5'd0;
    logic [31:0] exp_wd = 32'd0;
    int          blocked = 0;

    function automatic logic [31:0] exp_pend();
        logic [31:0] m;
        m = 32'd0;
        foreach (mq[i]) if (mq[i].rd != 5'd0) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        blocked = 0;
        exp_we  = 1'b0;
        exp_a3  = 5'd0;
        exp_wd  = 32'd0;
    endtask

    // Apply one cycle of inputs (called at a negedge), advance the model, return at next negedge.
    task automatic step(input logic wv, input logic [4:0] wrd, input logic [31:0] wdat,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        logic acc, psh, pp;
        wb_entry_t e, h;
        wb_valid = wv; wb_rd = wrd; wb_data = wdat;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ldat;
        acc = wv && (blocked != LIMIT);
        psh = lv && (mq.size() < DEPTH);
        pp  = !acc && (mq.size() > 0);
        if (acc) begin
            exp_we = (wrd != 5'd0);
            if (wrd != 5'd0) begin exp_a3 = wrd; exp_wd = wdat; end
        end else if (pp) begin
            h = mq[0];
            exp_we = (h.rd != 5'd0);
            if (h.rd != 5'd0) begin exp_a3 = h.rd; exp_wd = h.data; end
        end else begin
            exp_we = 1'b0;
        end
        if (mq.size() == 0 || pp) blocked = 0;
        else if (acc) blocked = blocked + 1;
        if (pp) void'(mq.pop_front());
        if (psh) begin e.rd = lrd; e.data = ldat; mq.push_back(e); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_vec++;
        if (we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'd0) begin
            n_err++; $display("FAIL reset_port: we3=%0b a3=%0d wd3=%h want 0/0/0", we3, a3, wd3);
        end
        n_vec++;
        if (fifo_count !== 3'd0 || pend_mask !== 32'd0) begin
            n_err++; $display("FAIL reset_fifo: count=%0d pend=%h want 0/0", fifo_count, pend_mask);
        end
        n_vec++;
        if (wb_ready !== 1'b1 || lsu_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: wb_ready=%0b lsu_ready=%0b want 1/1", wb_ready, lsu_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_vec++;
        if (wb_ready !== 1'b1 || lsu_ready !== 1'b1) begin
            n_err++; $display("FAIL post_reset_ready: wb_ready=%0b lsu_ready=%0b want 1/1", wb_ready, lsu_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_pipe_basic();
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        n_vec++;
        if (we3 !== 1'b1 || a3 !== 5'd5 || wd3 !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL pipe_write: we3=%0b a3=%0d wd3=%h want 1/5/deadbeef", we3, a3, wd3);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_vec++;
        if (we3 !== 1'b0 || a3 !== 5'd5) begin
            n_err++; $display("FAIL pipe_idle: we3=%0b a3=%0d want 0/5", we3, a3);
        end
    endtask

    task automatic test_lsu_basic();
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h11);
        n_vec++;
        if (pend_mask !== 32'h80 || we3 !== 1'b0 || fifo_count !== 3'd1) begin
            n_err++; $display("FAIL lsu_pend: pend=%h we3=%0b count=%0d want 80/0/1", pend_mask, we3, fifo_count);
        end
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        n_vec++;
        if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'h11 || pend_mask !== 32'd0) begin
            n_err++; $display("FAIL lsu_write: we3=%0b a3=%0d wd3=%h pend=%h want 1/7/11/0", we3, a3, wd3, pend_mask);
        end
    endtask

    task automatic test_starve();
        int run;
        logic lowr, lsu_iss;
        logic [4:0] order[$];
        for (int i = 1; i <= 4; i++) step(1'b1, 5'd9, $urandom, 1'b1, 5'(i), 32'h100 + i);
        n_vec++;
        if (fifo_count !== 3'd4 || lsu_ready !== 1'b0) begin
            n_err++; $display("FAIL starve_full: count=%0d lsu_ready=%0b want 4/0", fifo_count, lsu_ready);
        end
        run = 3;
        for (int c = 0; c < 40; c++) begin
            lowr = (wb_ready === 1'b0);
            step(1'b1, 5'd9, $urandom, 1'b0, 5'd0, 32'd0);
            lsu_iss = (we3 === 1'b1) && (a3 !== 5'd9);
            n_vec++;
            if (lowr !== lsu_iss) begin
                n_err++; $display("FAIL starve_ready: cycle %0d wb_ready_low=%0b lsu_issue=%0b want equal", c, lowr, lsu_iss);
            end
            if (we3 === 1'b1 && a3 === 5'd9) begin
                run++;
            end else if (lsu_iss) begin
                order.push_back(a3);
                n_vec++;
                if (run != LIMIT || wd3 !== 32'h100 + a3) begin
                    n_err++; $display("FAIL starve_run: rd=%0d run=%0d wd3=%h want run 7 data %h", a3, run, wd3, 32'h100 + a3);
                end
                run = 0;
            end
        end
        n_vec++;
        if (order.size() != 4) begin
            n_err++; $display("FAIL starve_count: issued %0d want 4", order.size());
        end
        for (int i = 0; i < order.size() && i < 4; i++) begin
            n_vec++;
            if (order[i] !== 5'(i + 1)) begin
                n_err++; $display("FAIL starve_order: slot %0d rd=%0d want %0d", i, order[i], i + 1);
            end
        end
    endtask

    task automatic test_rd_zero();
        for (int c = 0; c < 12; c++) begin
            step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, $urandom);
            n_vec++;
            if (we3 !== 1'b0 || pend_mask !== 32'd0) begin
                n_err++; $display("FAIL rd0_busy: cycle %0d we3=%0b pend=%h want 0/0", c, we3, pend_mask);
            end
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            n_vec++;
            if (we3 !== 1'b0) begin
                n_err++; $display("FAIL rd0_drain: cycle %0d we3=%0b want 0", c, we3);
            end
        end
        n_vec++;
        if (fifo_count !== 3'd0) begin
            n_err++; $display("FAIL rd0_empty: count=%0d want 0", fifo_count);
        end
    endtask

    task automatic test_full_pop();
        logic [4:0]  rds [4];
        logic [31:0] dats[4];
        for (int i = 0; i < 4; i++) begin
            rds[i]  = 5'($urandom_range(1, 31));
            dats[i] = $urandom;
            step(1'b1, 5'd3, $urandom, 1'b1, rds[i], dats[i]);
        end
        n_vec++;
        if (lsu_ready !== 1'b0 || fifo_count !== 3'd4) begin
            n_err++; $display("FAIL full_state: lsu_ready=%0b count=%0d want 0/4", lsu_ready, fifo_count);
        end
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hBAD0BAD0);
        n_vec++;
        if (fifo_count !== 3'd3 || we3 !== 1'b1 || a3 !== rds[0] || wd3 !== dats[0]) begin
            n_err++; $display("FAIL full_pop: count=%0d we3=%0b a3=%0d wd3=%h want 3/1/%0d/%h",
                              fifo_count, we3, a3, wd3, rds[0], dats[0]);
        end
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            n_vec++;
            if (we3 !== 1'b1 || a3 !== rds[i] || wd3 !== dats[i]) begin
                n_err++; $display("FAIL full_drain: slot %0d we3=%0b a3=%0d wd3=%h want 1/%0d/%h",
                                  i, we3, a3, wd3, rds[i], dats[i]);
            end
        end
        n_vec++;
        if (fifo_count !== 3'd0) begin
            n_err++; $display("FAIL full_empty: count=%0d want 0", fifo_count);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 5'd11, $urandom, 1'b1, 5'(i + 12), $urandom);
        n_vec++;
        if (fifo_count !== 3'd3 || we3 !== 1'b1) begin
            n_err++; $display("FAIL areset_pre: count=%0d we3=%0b want 3/1", fifo_count, we3);
        end
        wb_valid = 1'b0; lsu_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (we3 !== 1'b0 || fifo_count !== 3'd0 || pend_mask !== 32'd0 || a3 !== 5'd0) begin
            n_err++; $display("FAIL areset_now: we3=%0b count=%0d pend=%h a3=%0d want 0/0/0/0",
                              we3, fifo_count, pend_mask, a3);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            n_vec++;
            if (we3 !== 1'b0 || fifo_count !== 3'd0 || wb_ready !== 1'b1 || lsu_ready !== 1'b1) begin
                n_err++; $display("FAIL areset_after: cycle %0d we3=%0b count=%0d rdy=%0b/%0b want 0/0/1/1",
                                  c, we3, fifo_count, wb_ready, lsu_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            n_vec++;
            if (we3 !== exp_we || a3 !== exp_a3 || wd3 !== exp_wd ||
                wb_ready !== (blocked != LIMIT) || lsu_ready !== (mq.size() < DEPTH) ||
                fifo_count !== 3'(mq.size()) || pend_mask !== exp_pend()) begin
                n_err++;
                $display("FAIL random: cycle %0d got we3=%0b a3=%0d wd3=%h wbr=%0b lsr=%0b cnt=%0d pend=%h want %0b/%0d/%h/%0b/%0b/%0d/%h",
                         c, we3, a3, wd3, wb_ready, lsu_ready, fifo_count, pend_mask,
                         exp_we, exp_a3, exp_wd, (blocked != LIMIT), (mq.size() < DEPTH), mq.size(), exp_pend());
            end
            step(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 1) != 0), 5'($urandom_range(0, 7)), $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_pipe_basic();
        test_lsu_basic();
        test_starve();
        test_rd_zero();
        test_full_pop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_writer.md
REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 Parameter XLEN, 32, data width of register write port.
REQ-002 Parameter DEPTH, 4, late-writeback FIFO entries (power of two, >=2).
REQ-003 Parameter STARVE_LIMIT, 7, cycles FIFO head may be blocked by pipeline writebacks before forced drain.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 wb_valid  in  1  pipeline writeback request this cycle.
REQ-007 wb_rd  in  5  pipeline destination register.
REQ-008 wb_data  in  XLEN  pipeline writeback data.
REQ-009 wb_ready  out  1  pipeline writeback accepted when wb_valid && wb_ready.
REQ-010 lsu_valid  in  1  late (multicycle/load) writeback request.
REQ-011 lsu_rd  in  5  late destination register.
REQ-012 lsu_data  in  XLEN  late writeback data.
REQ-013 lsu_ready  out  1  FIFO can accept; push when lsu_valid && lsu_ready.
REQ-014 WE3  out  1  register-file write enable, registered.
REQ-015 A3  out  5  register-file write address, registered.
REQ-016 WD3  out  XLEN  register-file write data, registered.
REQ-017 pend_mask  out  32  bit r set while any valid FIFO entry targets register r.
REQ-018 fifo_count  out  clog2(DEPTH)+1  number of valid FIFO entries.

Function
REQ-019 At most one register write SHALL be issued per cycle; issue decision is combinational, WE3/A3/WD3 registered on the next posedge.
REQ-020 Pipeline path latency SHALL be 1 cycle: accepted at edge k -> WE3=1, A3=wb_rd, WD3=wb_data during cycle after edge k.
REQ-021 Late path SHALL always enqueue (no bypass); minimum latency push-edge k -> WE3 after edge k+1.
REQ-022 Priority: accepted pipeline request wins; otherwise FIFO head pops and issues if non-empty; otherwise WE3=0 (A3/WD3 hold last values).
REQ-023 Requests with rd=0 SHALL be accepted/popped but never assert WE3; rd=0 entries SHALL not set pend_mask bit 0.
REQ-024 lsu_ready SHALL equal (fifo_count < DEPTH), derived from registered count only; a pop in the same cycle does not raise lsu_ready.
REQ-025 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order; pointers wrap modulo DEPTH.
REQ-026 Starvation counter SHALL increment each cycle the FIFO is non-empty and an accepted pipeline write blocks the head; cleared on any pop or when FIFO empty.
REQ-027 When counter equals STARVE_LIMIT, wb_ready SHALL be 0 for exactly that cycle and the head SHALL issue; otherwise wb_ready=1.
REQ-028 No reordering or write merging: same-rd entries in FIFO and pipeline are written in issue order; hazard resolution uses pend_mask externally.
REQ-029 pend_mask and fifo_count SHALL reflect registered FIFO state (update one edge after push/pop).

Reset
REQ-030 While rst=1 (asynchronously): WE3=0, A3=0, WD3=0, FIFO pointers/count=0, pend_mask=0, starvation counter=0.
REQ-031 During and immediately after reset lsu_ready=1 and wb_ready=1; in-flight FIFO contents SHALL be discarded with no write issued.

Structure
REQ-032 XLEN, DEPTH default, STARVE_LIMIT default and a writeback-entry record (rd, data) SHALL live in the shared core package.
REQ-033 FIFO storage, pointers and count SHALL be one sub-module wb_fifo; arbitration, starvation counter and output registers stay in regfile_writer.

Verification
REQ-034 Reset then wb_valid=1, rd=5, data=0xDEADBEEF one cycle -> next cycle WE3=1, A3=5, WD3=0xDEADBEEF; following cycle WE3=0.
REQ-035 lsu push rd=7 data=0x11 with idle pipeline -> pend_mask=0x80 after 1 edge, WE3/A3=7/WD3=0x11 after 2 edges, pend_mask=0 after.
REQ-036 Push 4 lsu entries (rd 1..4) while wb_valid held with rd=9 -> lsu_ready=0 at count 4; 7 wb writes then wb_ready=0 one cycle and A3=1 issued; order 1,2,3,4 preserved.
REQ-037 wb_valid rd=0 data=0xFFFFFFFF and lsu rd=0 -> WE3 never asserted, pend_mask stays 0.
REQ-038 Full FIFO, simultaneous lsu push attempt and pop -> push rejected (lsu_ready=0), count goes 4->3.
REQ-039 Assert rst asynchronously mid-cycle with 3 entries queued -> WE3 falls immediately, count=0, no queued write appears after release.
